// File: rtl/t2t_pkg.sv
// Shared types for the strategy engine: compare modes, rule layout and its width.
// Default field widths used by the engine and its bench.
// The rule word is {en, mode[1:0], price_lim, vol_min, order}, en in the MSB.
package t2t_pkg;

    localparam int DEF_SYM_W      = 14;
    localparam int DEF_PRICE_W    = 64;
    localparam int DEF_VOL_W      = 32;
    localparam int DEF_ORDER_W    = 128;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BUY   = 2'b01,
        MODE_SELL  = 2'b10,
        MODE_EXACT = 2'b11
    } mode_e;

    typedef struct packed {
        logic                   en;
        mode_e                  mode;
        logic [DEF_PRICE_W-1:0] price_lim;
        logic [DEF_VOL_W-1:0]   vol_min;
        logic [DEF_ORDER_W-1:0] order;
    } rule_t;

    // Enable bit + 2 mode bits + the three data fields.
    function automatic int rule_w(input int price_w, input int vol_w, input int order_w);
        return 3 + price_w + vol_w + order_w;
    endfunction

endpackage

// File: rtl/tts_ofifo.sv
// tts_ofifo: synchronous order FIFO with occupancy count and async active-low reset.
// Latency: a push is visible on o_vld/o_rdata the cycle after the push edge.
// Backpressure: push when full and pop when empty are ignored; upstream reserves slots so neither occurs.
module tts_ofifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_vld,
    output logic [$clog2(DEPTH):0]     o_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_cnt != CW'(DEPTH));
    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_vld   = (r_cnt != '0);
    // Empty FIFO presents zero so order_data is 0 out of reset and between bursts.
    assign o_rdata = o_vld ? r_mem[r_rptr] : '0;
    assign o_cnt   = r_cnt;

    // Storage array: written on push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count tracks push/pop, unchanged when both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tts_gen2.sv
// tts_gen2: per-symbol rule lookup, mode-selected price/volume test, passing orders queued to the order port.
// Latency: accept edge N -> FIFO push edge N+2 -> order_valid in cycle N+3 with an empty FIFO.
// Backpressure: msg_ready only while FIFO count + in-flight messages < FIFO_DEPTH, so nothing overflows or drops.
module tts_gen2
    import t2t_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int PRICE_W    = DEF_PRICE_W,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int ORDER_W    = DEF_ORDER_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         msg_valid,
    output logic                                         msg_ready,
    input  logic [SYM_W-1:0]                             msg_symid,
    input  logic [PRICE_W-1:0]                           msg_price,
    input  logic [VOL_W-1:0]                             msg_vol,
    input  logic                                         cfg_we,
    input  logic [SYM_W-1:0]                             cfg_addr,
    input  logic [rule_w(PRICE_W, VOL_W, ORDER_W)-1:0]   cfg_rule,
    output logic                                         order_valid,
    input  logic                                         order_ready,
    output logic [ORDER_W-1:0]                           order_data,
    input  logic                                         stat_clr,
    output logic [31:0]                                  stat_msgs,
    output logic [31:0]                                  stat_orders
);

    localparam int RULE_W   = rule_w(PRICE_W, VOL_W, ORDER_W);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int VMIN_LSB = ORDER_W;
    localparam int PLIM_LSB = ORDER_W + VOL_W;
    localparam int MODE_LSB = ORDER_W + VOL_W + PRICE_W;
    localparam int EN_BIT   = RULE_W - 1;

    // Rule table and its registered read port.
    logic [RULE_W-1:0]  r_mem [2**SYM_W];
    logic [RULE_W-1:0]  r_rd_rule;

    // S1: message fields alongside valid RAM data; S2: registered compare verdict.
    logic               r_live;
    logic               r_s1_vld;
    logic [PRICE_W-1:0] r_s1_price;
    logic [VOL_W-1:0]   r_s1_vol;
    logic               r_s2_vld;
    logic               r_s2_pass;
    logic [ORDER_W-1:0] r_s2_order;
    logic [31:0]        r_stat_msgs;
    logic [31:0]        r_stat_orders;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_vld;
    logic [CNT_W-1:0]   w_fifo_cnt;
    logic [CNT_W:0]     w_occ;
    mode_e              w_mode;
    logic [PRICE_W-1:0] w_plim;
    logic [VOL_W-1:0]   w_vmin;
    logic               w_price_ok;
    logic               w_pass;

    // Every message in S1/S2 holds a reserved FIFO slot until it is pushed or fails its compare.
    assign w_occ     = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, r_s1_vld} + {{CNT_W{1'b0}}, r_s2_vld};
    assign msg_ready = r_live && (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_accept  = msg_valid && msg_ready;
    assign w_push    = r_s2_vld && r_s2_pass;
    assign w_pop     = w_fifo_vld && order_ready;

    assign order_valid = w_fifo_vld;
    assign stat_msgs   = r_stat_msgs;
    assign stat_orders = r_stat_orders;

    // Simple-dual-port table: host write and message read share the edge; the read sees the old word.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_mem[cfg_addr] <= cfg_rule;
        end
        if (w_accept) begin
            r_rd_rule <= r_mem[msg_symid];
        end
    end

    // Unsigned compare against the looked-up rule; enable and minimum volume gate every mode.
    always_comb begin
        w_mode     = mode_e'(r_rd_rule[MODE_LSB +: 2]);
        w_plim     = r_rd_rule[PLIM_LSB +: PRICE_W];
        w_vmin     = r_rd_rule[VMIN_LSB +: VOL_W];
        w_price_ok = 1'b0;
        case (w_mode)
            MODE_BUY:   w_price_ok = (r_s1_price <= w_plim);
            MODE_SELL:  w_price_ok = (r_s1_price >= w_plim);
            MODE_EXACT: w_price_ok = (r_s1_price == w_plim);
            default:    w_price_ok = 1'b0;
        endcase
        w_pass = r_rd_rule[EN_BIT] && (r_s1_vol >= w_vmin) && w_price_ok;
    end

    // Pipeline stages; r_live holds msg_ready low during reset and releases it one cycle after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live     <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_price <= '0;
            r_s1_vol   <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_pass  <= 1'b0;
            r_s2_order <= '0;
        end else begin
            r_live   <= 1'b1;
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_price <= msg_price;
                r_s1_vol   <= msg_vol;
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_pass <= r_s1_vld && w_pass;
            if (r_s1_vld) begin
                r_s2_order <= r_rd_rule[ORDER_W-1:0];
            end
        end
    end

    // Saturating statistics; a clear beats an increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_msgs   <= '0;
            r_stat_orders <= '0;
        end else begin
            if (stat_clr) begin
                r_stat_msgs <= '0;
            end else if (w_accept && (r_stat_msgs != 32'hFFFF_FFFF)) begin
                r_stat_msgs <= r_stat_msgs + 32'd1;
            end
            if (stat_clr) begin
                r_stat_orders <= '0;
            end else if (w_push && (r_stat_orders != 32'hFFFF_FFFF)) begin
                r_stat_orders <= r_stat_orders + 32'd1;
            end
        end
    end

    tts_ofifo #(
        .W     (ORDER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_wdata (r_s2_order),
        .i_pop   (w_pop),
        .o_rdata (order_data),
        .o_vld   (w_fifo_vld),
        .o_cnt   (w_fifo_cnt)
    );

endmodule

// File: tb/tb_tts_gen2.sv
// Bench for tts_gen2: directed scenarios plus randomized traffic against a queue-based reference model.
// Expected orders are queued at accept time from a model rule table and matched on each output handshake.
// Output backpressure is driven by a separate process in always-ready, always-stalled or random mode.
module tb_tts_gen2;
    import t2t_pkg::*;

    localparam int SW = DEF_SYM_W;
    localparam int PW = DEF_PRICE_W;
    localparam int VW = DEF_VOL_W;
    localparam int OW = DEF_ORDER_W;
    localparam int RW = rule_w(PW, VW, OW);

    logic          clk;
    logic          reset_n;
    logic          msg_valid;
    logic          msg_ready;
    logic [SW-1:0] msg_symid;
    logic [PW-1:0] msg_price;
    logic [VW-1:0] msg_vol;
    logic          cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [RW-1:0] cfg_rule;
    logic          order_valid;
    logic          order_ready;
    logic [OW-1:0] order_data;
    logic          stat_clr;
    logic [31:0]   stat_msgs;
    logic [31:0]   stat_orders;

    tts_gen2 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_symid   (msg_symid),
        .msg_price   (msg_price),
        .msg_vol     (msg_vol),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_rule    (cfg_rule),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_data  (order_data),
        .stat_clr    (stat_clr),
        .stat_msgs   (stat_msgs),
        .stat_orders (stat_orders)
    );

    int            n_cmp;
    int            n_bad;
    int            rdy_mode;
    bit            mon_en;
    rule_t         m_rule [16];
    logic [OW-1:0] exp_q [$];
    logic [31:0]   exp_msgs;
    logic [31:0]   exp_orders;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic rule_t mk_rule(input bit en, input mode_e mode, input logic [PW-1:0] lim,
                                      input logic [VW-1:0] vmin, input logic [OW-1:0] ord);
        rule_t r;
        r.en        = en;
        r.mode      = mode;
        r.price_lim = lim;
        r.vol_min   = vmin;
        r.order     = ord;
        return r;
    endfunction

    // Trading rule as stated: enable and volume floor, then the mode's price relation.
    function automatic bit model_pass(input rule_t r, input logic [PW-1:0] p, input logic [VW-1:0] v);
        if (!r.en || v < r.vol_min) return 1'b0;
        if (r.mode == MODE_BUY)   return p <= r.price_lim;
        if (r.mode == MODE_SELL)  return p >= r.price_lim;
        if (r.mode == MODE_EXACT) return p == r.price_lim;
        return 1'b0;
    endfunction

    function automatic void model_accept(input int sym, input logic [PW-1:0] p, input logic [VW-1:0] v);
        exp_msgs = sat_inc(exp_msgs);
        if (model_pass(m_rule[sym], p, v)) begin
            exp_q.push_back(m_rule[sym].order);
            exp_orders = sat_inc(exp_orders);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic write_rule(input int sym, input rule_t r);
        cfg_we   = 1'b1;
        cfg_addr = SW'(sym);
        cfg_rule = r;
        @(negedge clk);
        cfg_we = 1'b0;
        m_rule[sym] = r;
    endtask

    task automatic send_msg(input int sym, input logic [PW-1:0] p, input logic [VW-1:0] v);
        int waited = 0;
        msg_symid = SW'(sym);
        msg_price = p;
        msg_vol   = v;
        msg_valid = 1'b1;
        while (!msg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!msg_ready) begin
            chk("msg_ready_timeout", msg_ready, 1'b1);
            msg_valid = 1'b0;
        end else begin
            model_accept(sym, p, v);
            @(negedge clk);
            msg_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_pending_orders"}, 128'(exp_q.size()), 128'd0);
        chk({tag, "_order_valid_idle"}, order_valid, 1'b0);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_stat_msgs"}, stat_msgs, exp_msgs);
        chk({tag, "_stat_orders"}, stat_orders, exp_orders);
    endtask

    // Downstream ready generator: 0 always ready, 1 stalled, 2 random.
    initial begin
        order_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       order_ready = 1'b1;
                1:       order_ready = 1'b0;
                default: order_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor: matches each handshake against the model queue and checks hold-while-stalled.
    initial begin
        bit            stall_prev;
        logic [OW-1:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && order_valid) begin
                    chk("order_data_hold", order_data, held);
                end
                if (order_valid && order_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_order", 128'(exp_q.size()), 128'd1);
                    end else begin
                        chk("order_payload", order_data, exp_q.pop_front());
                    end
                end
                stall_prev = order_valid && !order_ready;
                held       = order_data;
            end
        end
    end

    initial begin
        rule_t r;
        int    sym;
        int    d;
        n_cmp      = 0;
        n_bad      = 0;
        rdy_mode   = 0;
        mon_en     = 1'b0;
        exp_msgs   = '0;
        exp_orders = '0;
        reset_n    = 1'b0;
        msg_valid  = 1'b0;
        msg_symid  = '0;
        msg_price  = '0;
        msg_vol    = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_rule   = '0;
        stat_clr   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_msg_ready", msg_ready, 1'b0);
        chk("rst_order_valid", order_valid, 1'b0);
        chk("rst_order_data", order_data, '0);
        chk("rst_stat_msgs", stat_msgs, '0);
        chk("rst_stat_orders", stat_orders, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("msg_ready_after_rst", msg_ready, 1'b1);
        mon_en = 1'b1;

        // 1: BUY pass, latency to order_valid
        write_rule(5, mk_rule(1'b1, MODE_BUY, 64'd100, 32'd10, 128'hA5));
        send_msg(5, 64'd99, 32'd10);
        chk("t1_valid_cyc_n1", order_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_cyc_n2", order_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_cyc_n3", order_valid, 1'b1);
        chk("t1_data_cyc_n3", order_data, 128'hA5);
        drain("t1");
        chk_stats("t1");

        // 2: price/volume fails, mode OFF, disabled rule
        send_msg(5, 64'd101, 32'd10);
        send_msg(5, 64'd99, 32'd9);
        write_rule(5, mk_rule(1'b1, MODE_OFF, 64'd100, 32'd10, 128'hA6));
        send_msg(5, 64'd99, 32'd10);
        write_rule(5, mk_rule(1'b0, MODE_BUY, 64'd100, 32'd10, 128'hA7));
        send_msg(5, 64'd99, 32'd10);
        drain("t2");
        chk_stats("t2");

        // 3: SELL and EXACT boundaries
        write_rule(3, mk_rule(1'b1, MODE_SELL, 64'd100, 32'd1, 128'h5E11));
        write_rule(4, mk_rule(1'b1, MODE_EXACT, 64'd100, 32'd1, 128'hE0AC7));
        send_msg(3, 64'd100, 32'd20);
        send_msg(4, 64'd100, 32'd20);
        send_msg(4, 64'd101, 32'd20);
        drain("t3");
        chk_stats("t3");

        // 4: stalled output, reservation limit, release
        for (int i = 8; i < 14; i++) begin
            write_rule(i, mk_rule(1'b1, MODE_BUY, 64'd1000, 32'd0, 128'h4000 + 128'(i)));
        end
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        for (int i = 8; i < 12; i++) begin
            send_msg(i, 64'd500, 32'd1);
        end
        chk("t4_ready_low_after_4", msg_ready, 1'b0);
        repeat (5) @(negedge clk);
        chk("t4_ready_still_low", msg_ready, 1'b0);
        chk("t4_valid_stalled", order_valid, 1'b1);
        chk("t4_head_data", order_data, exp_q[0]);
        fork
            send_msg(12, 64'd500, 32'd1);
            begin
                repeat (3) @(negedge clk);
                rdy_mode = 0;
            end
        join
        send_msg(13, 64'd500, 32'd1);
        drain("t4");
        chk_stats("t4");

        // 5: host write colliding with a read of the same address
        write_rule(7, mk_rule(1'b1, MODE_BUY, 64'd100, 32'd0, 128'h77));
        chk("t5_ready_idle", msg_ready, 1'b1);
        r = mk_rule(1'b1, MODE_BUY, 64'd200, 32'd0, 128'h78);
        cfg_we    = 1'b1;
        cfg_addr  = SW'(7);
        cfg_rule  = r;
        msg_symid = SW'(7);
        msg_price = 64'd150;
        msg_vol   = 32'd5;
        msg_valid = 1'b1;
        model_accept(7, 64'd150, 32'd5);
        m_rule[7] = r;
        @(negedge clk);
        cfg_we    = 1'b0;
        msg_valid = 1'b0;
        send_msg(7, 64'd150, 32'd5);
        drain("t5");
        chk_stats("t5");

        // Randomized traffic with random backpressure and occasional rule rewrites
        for (int s = 0; s < 16; s++) begin
            r = mk_rule($urandom_range(0, 7) != 0, mode_e'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : 64'($urandom_range(50, 1000)),
                        32'($urandom_range(0, 40)), {$urandom, $urandom, $urandom, $urandom});
            write_rule(s, r);
        end
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            sym = $urandom_range(0, 15);
            if ($urandom_range(0, 19) == 0) begin
                r = m_rule[sym];
                r.mode  = mode_e'($urandom_range(0, 3));
                r.order = {$urandom, $urandom, $urandom, $urandom};
                write_rule(sym, r);
            end
            d = int'($urandom_range(0, 4)) - 2;
            send_msg(sym, m_rule[sym].price_lim + 64'(d),
                     m_rule[sym].vol_min + 32'(int'($urandom_range(0, 4)) - 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain("rand");
        chk_stats("rand");

        // 6: saturation, clear priority, asynchronous reset mid-stream
        force dut.r_stat_msgs = 32'hFFFF_FFFE;
        force dut.r_stat_orders = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_stat_msgs;
        release dut.r_stat_orders;
        exp_msgs   = 32'hFFFF_FFFE;
        exp_orders = 32'hFFFF_FFFE;
        write_rule(5, mk_rule(1'b1, MODE_BUY, 64'd100, 32'd10, 128'hA5));
        for (int i = 0; i < 3; i++) begin
            send_msg(5, 64'd99, 32'd10);
        end
        drain("t6_sat");
        chk_stats("t6_sat");
        stat_clr = 1'b1;
        send_msg(5, 64'd101, 32'd10);
        stat_clr   = 1'b0;
        exp_msgs   = '0;
        exp_orders = '0;
        @(negedge clk);
        chk_stats("t6_clr");

        rdy_mode = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send_msg(5, 64'd90, 32'd10);
        end
        repeat (4) @(negedge clk);
        chk("t6_fifo_loaded", order_valid, 1'b1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_order_valid", order_valid, 1'b0);
        chk("t6_rst_order_data", order_data, '0);
        chk("t6_rst_msg_ready", msg_ready, 1'b0);
        exp_q.delete();
        exp_msgs   = '0;
        exp_orders = '0;
        chk_stats("t6_rst");
        @(negedge clk);
        reset_n  = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        chk("t6_ready_after_rst", msg_ready, 1'b1);
        mon_en = 1'b1;
        send_msg(5, 64'd99, 32'd10);
        drain("t6_post");
        chk_stats("t6_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
